// File: rtl/line_burst_pkg.sv
// Shared types and geometry for the cache-line to memory-burst adapter.
package line_burst_pkg;

    localparam int unsigned S_ADDR   = 32;
    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned S_LINE   = 256;
    localparam int unsigned S_BURST  = 64;
    localparam int unsigned S_BEATS  = S_LINE / S_BURST;
    localparam int unsigned S_CNT    = $clog2(S_BEATS);

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [S_ADDR-1:0] LINE_MASK = ~S_ADDR'(2 ** S_OFFSET - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adapter_state_t;

    // Line-aligned form of a cache address.
    function automatic logic [S_ADDR-1:0] line_align(input logic [S_ADDR-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/line_burst_if.sv
// Cache-side line port and memory-side burst port of the adapter.
interface line_burst_if;
    import line_burst_pkg::*;

    logic [S_ADDR-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic [S_LINE-1:0]  line_i;
    logic [S_LINE-1:0]  line_o;
    logic               resp_o;
    logic [S_ADDR-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic [S_BURST-1:0] burst_o;
    logic [S_BURST-1:0] burst_i;
    logic               resp_i;

    // Adapter view.
    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    // Environment view: the cache and the memory together.
    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );

endinterface

// File: rtl/line_burst_adapter.sv
// Buffers a whole cache line and moves it to/from memory as a sequence of beats.
module line_burst_adapter
    import line_burst_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    line_burst_if.slave  bus
);

    adapter_state_t    state;
    logic [S_CNT-1:0]  cnt;
    logic [S_LINE-1:0] buffer;
    logic              in_burst;
    logic              last_beat;

    assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
    assign last_beat = bus.resp_i && (cnt == S_CNT'(S_BEATS - 1));

    // Cache sees the buffer directly; memory sees the beat selected by the counter.
    assign bus.line_o  = buffer;
    assign bus.burst_o = buffer[S_BURST * 32'(cnt) +: S_BURST];

    // Control FSM with registered request/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.read_o    <= 1'b0;
            bus.write_o   <= 1'b0;
            bus.resp_o    <= 1'b0;
            bus.address_o <= '0;
        end else begin
            bus.resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.write_i) begin
                        bus.address_o <= line_align(bus.address_i);
                        bus.write_o   <= 1'b1;
                        state         <= WR_BURST;
                    end else if (bus.read_i) begin
                        bus.address_o <= line_align(bus.address_i);
                        bus.read_o    <= 1'b1;
                        state         <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (last_beat) begin
                        bus.read_o <= 1'b0;
                        bus.resp_o <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR_BURST: begin
                    if (last_beat) begin
                        bus.write_o <= 1'b0;
                        bus.resp_o  <= 1'b1;
                        state       <= DONE;
                    end
                end
                // Requests are still high here; ignoring them prevents a repeat burst.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat counter: advances only on strobes inside a burst, cleared after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_burst && bus.resp_i) begin
            if (last_beat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + S_CNT'(1);
            end
        end
    end

    // Line buffer: whole-line load for writes, beat-wise fill for reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
        end else if (state == IDLE && bus.write_i) begin
            buffer <= bus.line_i;
        end else if (state == RD_BURST && bus.resp_i) begin
            buffer[S_BURST * 32'(cnt) +: S_BURST] <= bus.burst_i;
        end
    end

endmodule
